// File: rtl/calc_stream_ctrl.sv
// ---------------------------------------------------------------------------
// calc_stream_ctrl
//
// Streaming reduce controller for a split lower/upper SRAM pair. After a
// start request it reads operand words {rdata_hi, rdata_lo} from a read
// window, reduces each group of OPS consecutive operands with add or
// subtract, and writes one 2*DATA_W result per group into a write window.
// A run ends when the next operand group would pass the read end address
// or when the last write-window address has been written. A trailing
// partial group is never read and never written.
//
// Optional feature (compile-time macro CALC_SAT_EN):
//   defined   : unsigned saturating arithmetic (carry clamps the
//               accumulator to all-ones, borrow clamps it to zero)
//   undefined : modulo 2^(2*DATA_W) arithmetic
//   ovf is set on carry/borrow in both builds; timing is identical.
//
// Parameters:
//   DATA_W  width of each SRAM half (operand/result is 2*DATA_W bits)
//   ADDR_W  SRAM address width
//   OPS     operands reduced per result (2..16)
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   start                one-cycle run request (taken in S_IDLE / S_END)
//   mode                 0 = add, 1 = subtract (op0 - op1 - ...)
//   read_start_addr      first operand address
//   read_end_addr        last operand address (inclusive)
//   write_start_addr     first result address
//   write_end_addr       last result address (inclusive)
//   rd_en, r_addr        read strobe and shared read address
//   rdata_lo, rdata_hi   SRAM read data, valid one cycle after rd_en
//   wr_en, w_addr        write strobe and write address
//   wdata_lo, wdata_hi   result low / high halves
//   busy                 high in S_READ / S_ACC / S_WRITE
//   done                 high while in S_END
//   err                  range error for the current run
//   ovf                  sticky carry/borrow flag for the current run
//   cycle_count          cycles from start acceptance to S_END entry
//   results_written      results written this run
// ---------------------------------------------------------------------------
module calc_stream_ctrl #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10,
    parameter int OPS    = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                mode,
    input  logic [ADDR_W-1:0]   read_start_addr,
    input  logic [ADDR_W-1:0]   read_end_addr,
    input  logic [ADDR_W-1:0]   write_start_addr,
    input  logic [ADDR_W-1:0]   write_end_addr,
    output logic                rd_en,
    output logic [ADDR_W-1:0]   r_addr,
    input  logic [DATA_W-1:0]   rdata_lo,
    input  logic [DATA_W-1:0]   rdata_hi,
    output logic                wr_en,
    output logic [ADDR_W-1:0]   w_addr,
    output logic [DATA_W-1:0]   wdata_lo,
    output logic [DATA_W-1:0]   wdata_hi,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic                ovf,
    output logic [31:0]         cycle_count,
    output logic [ADDR_W:0]     results_written
);

    localparam int ACC_W = 2 * DATA_W;
    localparam int K_W   = (OPS > 1) ? $clog2(OPS) : 1;
    // Wide enough that address + OPS never wraps, so end-of-window tests
    // stay correct right up to address 2^ADDR_W-1.
    localparam int CMP_W = ADDR_W + 6;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_ACC,
        S_WRITE,
        S_END
    } state_t;

    state_t              state;
    logic [ADDR_W-1:0]   rd_end_q;
    logic [ADDR_W-1:0]   wr_end_q;
    logic                mode_q;
    logic                more_groups;
    logic [K_W-1:0]      op_idx;
    logic [ACC_W-1:0]    acc;

    logic [ACC_W-1:0]    operand;
    logic [ACC_W:0]      sum_ext;
    logic [ACC_W:0]      diff_ext;
    logic                range_err;
    logic                first_fits;
    logic                next_fits;
    logic                last_op;

    assign operand  = {rdata_hi, rdata_lo};

    // The extra top bit is the carry (add) or the borrow (subtract).
    assign sum_ext  = {1'b0, acc} + {1'b0, operand};
    assign diff_ext = {1'b0, acc} - {1'b0, operand};

    assign range_err  = (read_start_addr > read_end_addr) ||
                        (write_start_addr > write_end_addr);

    // A run whose read window is shorter than one group has nothing to
    // write, so it finishes immediately without touching the SRAMs.
    assign first_fits = (CMP_W'(read_start_addr) + CMP_W'(OPS - 1)) <=
                        CMP_W'(read_end_addr);

    // Evaluated on the last operand of a group, when r_addr holds the last
    // address of that group: the next group ends OPS addresses later.
    assign next_fits  = (CMP_W'(r_addr) + CMP_W'(OPS)) <= CMP_W'(rd_end_q);

    assign last_op    = (op_idx == K_W'(OPS - 1));

    assign wdata_lo   = acc[DATA_W-1:0];
    assign wdata_hi   = acc[ACC_W-1:DATA_W];

    // Main controller: one registered FSM that owns every strobe, address,
    // flag and counter. rd_en and wr_en default low each cycle and are
    // raised only on the transition into S_READ / S_WRITE, so each is a
    // single-cycle pulse aligned with its state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= S_IDLE;
            rd_en           <= 1'b0;
            wr_en           <= 1'b0;
            r_addr          <= '0;
            w_addr          <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            err             <= 1'b0;
            ovf             <= 1'b0;
            cycle_count     <= '0;
            results_written <= '0;
            acc             <= '0;
            op_idx          <= '0;
            rd_end_q        <= '0;
            wr_end_q        <= '0;
            mode_q          <= 1'b0;
            more_groups     <= 1'b0;
        end else begin
            rd_en <= 1'b0;
            wr_en <= 1'b0;

            if (busy && (cycle_count != '1)) begin
                cycle_count <= cycle_count + 32'd1;
            end

            case (state)
                S_IDLE, S_END: begin
                    if (start) begin
                        mode_q          <= mode;
                        rd_end_q        <= read_end_addr;
                        wr_end_q        <= write_end_addr;
                        r_addr          <= read_start_addr;
                        w_addr          <= write_start_addr;
                        err             <= 1'b0;
                        ovf             <= 1'b0;
                        // The acceptance cycle itself is counted.
                        cycle_count     <= 32'd1;
                        results_written <= '0;
                        acc             <= '0;
                        op_idx          <= '0;
                        more_groups     <= 1'b0;
                        if (range_err) begin
                            err   <= 1'b1;
                            state <= S_END;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else if (!first_fits) begin
                            state <= S_END;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state <= S_READ;
                            busy  <= 1'b1;
                            done  <= 1'b0;
                            rd_en <= 1'b1;
                        end
                    end
                end

                S_READ: begin
                    state <= S_ACC;
                end

                S_ACC: begin
                    if (op_idx == '0) begin
                        acc <= operand;
                    end else if (mode_q) begin
                        if (diff_ext[ACC_W]) begin
                            ovf <= 1'b1;
`ifdef CALC_SAT_EN
                            acc <= '0;
`else
                            acc <= diff_ext[ACC_W-1:0];
`endif
                        end else begin
                            acc <= diff_ext[ACC_W-1:0];
                        end
                    end else begin
                        if (sum_ext[ACC_W]) begin
                            ovf <= 1'b1;
`ifdef CALC_SAT_EN
                            acc <= '1;
`else
                            acc <= sum_ext[ACC_W-1:0];
`endif
                        end else begin
                            acc <= sum_ext[ACC_W-1:0];
                        end
                    end

                    if (!last_op) begin
                        op_idx <= op_idx + 1'b1;
                        r_addr <= r_addr + 1'b1;
                        state  <= S_READ;
                        rd_en  <= 1'b1;
                    end else begin
                        op_idx      <= '0;
                        more_groups <= next_fits;
                        // Only step the read pointer when another whole
                        // group follows; this keeps r_addr from running
                        // past the read end (and from wrapping to 0).
                        if (next_fits) begin
                            r_addr <= r_addr + 1'b1;
                        end
                        state <= S_WRITE;
                        wr_en <= 1'b1;
                    end
                end

                S_WRITE: begin
                    results_written <= results_written + 1'b1;
                    if (!more_groups || (w_addr == wr_end_q)) begin
                        state <= S_END;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        w_addr <= w_addr + 1'b1;
                        state  <= S_READ;
                        rd_en  <= 1'b1;
                    end
                end

                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_calc_stream_ctrl.sv
// ---------------------------------------------------------------------------
// tb_calc_stream_ctrl
//
// Self-checking bench for calc_stream_ctrl (DATA_W=32, ADDR_W=10, OPS=2).
// A behavioural SRAM pair feeds the DUT; every run computes its expected
// writes from the memory contents and queues them, and each DUT write is
// popped and compared as it happens. End-of-run counters and flags are
// compared against the same model.
// ---------------------------------------------------------------------------
module tb_calc_stream_ctrl;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 10;
    localparam int OPS    = 2;
    localparam int DEPTH  = 1 << ADDR_W;

    logic                clk_tb = 1'b0;
    logic                rst_n;
    logic                start;
    logic                mode;
    logic [ADDR_W-1:0]   read_start_addr;
    logic [ADDR_W-1:0]   read_end_addr;
    logic [ADDR_W-1:0]   write_start_addr;
    logic [ADDR_W-1:0]   write_end_addr;
    logic                rd_en;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   rdata_lo = '0;
    logic [DATA_W-1:0]   rdata_hi = '0;
    logic                wr_en;
    logic [ADDR_W-1:0]   w_addr;
    logic [DATA_W-1:0]   wdata_lo;
    logic [DATA_W-1:0]   wdata_hi;
    logic                busy;
    logic                done;
    logic                err;
    logic                ovf;
    logic [31:0]         cycle_count;
    logic [ADDR_W:0]     results_written;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [63:0]       data;
    } wr_exp_t;

    wr_exp_t            exp_q[$];
    logic [DATA_W-1:0]  lo_mem [0:DEPTH-1];
    logic [DATA_W-1:0]  hi_mem [0:DEPTH-1];

    int   assert_count = 0;
    int   fail_count   = 0;
    int   rd_total     = 0;
    int   wr_total     = 0;
    int   rd_snap      = 0;
    int   exp_results  = 0;
    int   exp_cycles   = 0;
    int   exp_reads    = 0;
    logic exp_ovf      = 1'b0;
    logic exp_err      = 1'b0;

    always #5 clk_tb = ~clk_tb;

    calc_stream_ctrl #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .OPS    (OPS)
    ) dut (
        .clk              (clk_tb),
        .rst_n            (rst_n),
        .start            (start),
        .mode             (mode),
        .read_start_addr  (read_start_addr),
        .read_end_addr    (read_end_addr),
        .write_start_addr (write_start_addr),
        .write_end_addr   (write_end_addr),
        .rd_en            (rd_en),
        .r_addr           (r_addr),
        .rdata_lo         (rdata_lo),
        .rdata_hi         (rdata_hi),
        .wr_en            (wr_en),
        .w_addr           (w_addr),
        .wdata_lo         (wdata_lo),
        .wdata_hi         (wdata_hi),
        .busy             (busy),
        .done             (done),
        .err              (err),
        .ovf              (ovf),
        .cycle_count      (cycle_count),
        .results_written  (results_written)
    );

    // Synchronous SRAM read port: data appears the cycle after rd_en.
    always @(posedge clk_tb) begin
        if (rd_en) begin
            rdata_lo <= lo_mem[r_addr];
            rdata_hi <= hi_mem[r_addr];
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        assert_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic initMem();
        for (int i = 0; i < DEPTH; i++) begin
            lo_mem[i] = 32'(i);
            hi_mem[i] = '0;
        end
    endtask

    // Advance to the next falling edge and act as the SRAM write port and
    // write monitor there, away from the DUT's active edge.
    task automatic tick();
        wr_exp_t e;
        @(negedge clk_tb);
        if (rd_en) rd_total++;
        if (wr_en) begin
            wr_total++;
            lo_mem[w_addr] = wdata_lo;
            hi_mem[w_addr] = wdata_hi;
            if (exp_q.size() == 0) begin
                checkOutput("spurious_wr", 64'(wr_en), 64'd0);
            end else begin
                e = exp_q.pop_front();
                checkOutput("w_addr", 64'(w_addr), 64'(e.addr));
                checkOutput("wdata", {wdata_hi, wdata_lo}, e.data);
            end
        end
    endtask

    // Build the expected result stream for one run, then pulse start.
    task automatic applyStimulus(input logic m, input int rs, input int re,
                                 input int ws, input int we);
        logic [63:0] acc_m;
        logic [63:0] op;
        logic [64:0] t;
        wr_exp_t     e;
        int          base;
        exp_results = 0;
        exp_ovf     = 1'b0;
        exp_err     = (rs > re) || (ws > we);
        if (!exp_err) begin
            for (int g = 0; g < DEPTH; g++) begin
                base = rs + g * OPS;
                if ((base + OPS - 1 > re) || (ws + g > we)) break;
                acc_m = '0;
                for (int k = 0; k < OPS; k++) begin
                    op = {hi_mem[base + k], lo_mem[base + k]};
                    if (k == 0) begin
                        acc_m = op;
                    end else if (!m) begin
                        t = {1'b0, acc_m} + {1'b0, op};
                        if (t[64]) begin
                            exp_ovf = 1'b1;
`ifdef CALC_SAT_EN
                            acc_m = '1;
`else
                            acc_m = t[63:0];
`endif
                        end else begin
                            acc_m = t[63:0];
                        end
                    end else begin
                        if (acc_m < op) begin
                            exp_ovf = 1'b1;
`ifdef CALC_SAT_EN
                            acc_m = '0;
`else
                            acc_m = acc_m - op;
`endif
                        end else begin
                            acc_m = acc_m - op;
                        end
                    end
                end
                e.addr = ADDR_W'(ws + g);
                e.data = acc_m;
                exp_q.push_back(e);
                exp_results++;
            end
        end
        exp_cycles = exp_results * (2 * OPS + 1) + 1;
        exp_reads  = exp_results * OPS;

        mode             = m;
        read_start_addr  = ADDR_W'(rs);
        read_end_addr    = ADDR_W'(re);
        write_start_addr = ADDR_W'(ws);
        write_end_addr   = ADDR_W'(we);
        rd_snap          = rd_total;
        start            = 1'b1;
        tick();
        start            = 1'b0;
    endtask

    task automatic waitDone(input string tag);
        for (int i = 0; i < 3000 && !done; i++) tick();
        checkOutput({tag, "/done"}, 64'(done), 64'd1);
    endtask

    task automatic checkRun(input string tag);
        checkOutput({tag, "/results"}, 64'(results_written), 64'(exp_results));
        checkOutput({tag, "/cycles"}, 64'(cycle_count), 64'(exp_cycles));
        checkOutput({tag, "/err"}, 64'(err), 64'(exp_err));
        checkOutput({tag, "/ovf"}, 64'(ovf), 64'(exp_ovf));
        checkOutput({tag, "/busy"}, 64'(busy), 64'd0);
        checkOutput({tag, "/reads"}, 64'(rd_total - rd_snap), 64'(exp_reads));
        checkOutput({tag, "/pending"}, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        int wr_snap;
        rst_n            = 1'b0;
        start            = 1'b0;
        mode             = 1'b0;
        read_start_addr  = '0;
        read_end_addr    = '0;
        write_start_addr = '0;
        write_end_addr   = '0;
        initMem();
        repeat (3) tick();

        checkOutput("rst/busy", 64'(busy), 64'd0);
        checkOutput("rst/done", 64'(done), 64'd0);
        checkOutput("rst/rd_en", 64'(rd_en), 64'd0);
        checkOutput("rst/wr_en", 64'(wr_en), 64'd0);
        checkOutput("rst/cycles", 64'(cycle_count), 64'd0);
        checkOutput("rst/results", 64'(results_written), 64'd0);
        rst_n = 1'b1;
        tick();

        // Baseline add run.
        applyStimulus(1'b0, 0, 511, 768, 1023);
        waitDone("base");
        checkRun("base");
        checkOutput("base/cycles_abs", 64'(cycle_count), 64'd1281);
        checkOutput("base/results_abs", 64'(results_written), 64'd256);
        for (int j = 0; j < 256; j++) begin
            checkOutput("base/mem", {hi_mem[768 + j], lo_mem[768 + j]}, 64'(4 * j + 1));
        end

        // Subtract without and with borrow.
        lo_mem[0] = 32'd10;
        lo_mem[1] = 32'd3;
        applyStimulus(1'b1, 0, 1, 200, 200);
        waitDone("sub");
        checkRun("sub");
        checkOutput("sub/mem", {hi_mem[200], lo_mem[200]}, 64'd7);
        lo_mem[0] = 32'd3;
        lo_mem[1] = 32'd10;
        applyStimulus(1'b1, 0, 1, 201, 201);
        waitDone("subb");
        checkRun("subb");
`ifdef CALC_SAT_EN
        checkOutput("subb/mem", {hi_mem[201], lo_mem[201]}, 64'd0);
`else
        checkOutput("subb/mem", {hi_mem[201], lo_mem[201]}, 64'hFFFF_FFFF_FFFF_FFF9);
`endif
        checkOutput("subb/ovf_abs", 64'(ovf), 64'd1);
        initMem();

        // Write window smaller than the read window.
        applyStimulus(1'b0, 0, 7, 100, 101);
        waitDone("win");
        checkRun("win");
        checkOutput("win/results_abs", 64'(results_written), 64'd2);

        // Trailing partial group is dropped.
        applyStimulus(1'b0, 0, 4, 300, 310);
        waitDone("part");
        checkRun("part");
        checkOutput("part/results_abs", 64'(results_written), 64'd2);
        checkOutput("part/reads_abs", 64'(rd_total - rd_snap), 64'd4);

        // Read window ending at the top address must not wrap.
        applyStimulus(1'b0, 1020, 1023, 400, 409);
        waitDone("top");
        checkRun("top");
        checkOutput("top/r_addr", 64'(r_addr), 64'd1023);

        // Range errors: done and err the cycle after start, no SRAM traffic.
        wr_snap = wr_total;
        applyStimulus(1'b0, 20, 10, 0, 5);
        checkOutput("rerr/done_now", 64'(done), 64'd1);
        checkOutput("rerr/err_now", 64'(err), 64'd1);
        repeat (4) tick();
        checkRun("rerr");
        checkOutput("rerr/writes", 64'(wr_total - wr_snap), 64'd0);
        applyStimulus(1'b0, 0, 7, 50, 40);
        repeat (2) tick();
        checkRun("werr");

        // Asynchronous reset while in S_ACC.
        applyStimulus(1'b0, 0, 511, 768, 1023);
        @(posedge clk_tb);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("arst/busy", 64'(busy), 64'd0);
        checkOutput("arst/rd_en", 64'(rd_en), 64'd0);
        checkOutput("arst/wr_en", 64'(wr_en), 64'd0);
        checkOutput("arst/r_addr", 64'(r_addr), 64'd0);
        checkOutput("arst/cycles", 64'(cycle_count), 64'd0);
        checkOutput("arst/wdata", {wdata_hi, wdata_lo}, 64'd0);
        exp_q.delete();
        wr_snap = wr_total;
        repeat (4) tick();
        checkOutput("arst/no_wr", 64'(wr_total - wr_snap), 64'd0);
        rst_n = 1'b1;
        tick();
        applyStimulus(1'b0, 0, 511, 768, 1023);
        waitDone("rerun");
        checkRun("rerun");

        // start while busy is ignored; start in S_END runs afresh.
        applyStimulus(1'b0, 0, 7, 500, 503);
        repeat (3) tick();
        mode             = 1'b1;
        read_start_addr  = 10'd40;
        read_end_addr    = 10'd41;
        write_start_addr = 10'd900;
        write_end_addr   = 10'd900;
        start            = 1'b1;
        tick();
        start            = 1'b0;
        waitDone("busy_start");
        checkRun("busy_start");
        applyStimulus(1'b1, 8, 11, 600, 601);
        waitDone("restart");
        checkRun("restart");

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule

// File: doc/calc_stream_ctrl.md
Name: calc_stream_ctrl

Overview:
Parametrised successor to the calculator controller in top_lvl. The block streams operand words from the split lower/upper SRAM pair and reduces each group of OPS consecutive words with add or subtract. It writes one 2*DATA_W result per group back into a programmable write window. It adds a start/done handshake, a runtime mode, range error detection, a sticky overflow flag and a cycle counter.

Parameters:
DATA_W, 32, width of each SRAM half; an operand/result is 2*DATA_W bits as {hi,lo}
ADDR_W, 10, SRAM address width
OPS, 2, operands reduced per result (2..16)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle request; accepted only in S_IDLE or S_END
mode  in  1  0 = add, 1 = subtract (op0 - op1 - ... - op(OPS-1))
read_start_addr  in  ADDR_W  first operand address
read_end_addr  in  ADDR_W  last operand address (inclusive)
write_start_addr  in  ADDR_W  first result address
write_end_addr  in  ADDR_W  last result address (inclusive)
rd_en  out  1  read strobe to both SRAMs
r_addr  out  ADDR_W  read address, shared by both SRAMs
rdata_lo  in  DATA_W  lower-SRAM data, valid 1 cycle after rd_en
rdata_hi  in  DATA_W  upper-SRAM data, valid 1 cycle after rd_en
wr_en  out  1  write strobe to both SRAMs
w_addr  out  ADDR_W  write address
wdata_lo  out  DATA_W  result[DATA_W-1:0]
wdata_hi  out  DATA_W  result[2*DATA_W-1:DATA_W]
busy  out  1  high in S_READ/S_ACC/S_WRITE
done  out  1  high while in S_END
err  out  1  range error for the current run
ovf  out  1  sticky carry/borrow flag for the current run
cycle_count  out  32  cycles from start acceptance to S_END entry
results_written  out  ADDR_W+1  results written this run

Behaviour:
- Reset (async, rst_n=0): state S_IDLE. All outputs 0; accumulator and counters 0. An in-flight write is not issued.
- start accepted: latch all addresses and mode. Clear err, ovf, cycle_count and results_written. r_addr = read_start_addr, w_addr = write_start_addr. Go to S_READ, or to S_END with err=1 if read_start_addr > read_end_addr or write_start_addr > write_end_addr.
- start while busy is ignored.
- S_READ: rd_en=1 for one cycle at r_addr. Next state S_ACC.
- S_ACC: capture {rdata_hi,rdata_lo}.
  - Operand k=0 loads the accumulator.
  - k>0: acc = acc ± operand, modulo 2^(2*DATA_W). Any carry-out (add) or borrow (sub) sets ovf.
  - r_addr increments.
  - If k < OPS-1: go to S_READ. Else go to S_WRITE.
- S_WRITE: wr_en=1 for exactly one cycle with w_addr and wdata = acc; results_written increments. Then:
  - Go to S_END if the next read group would pass read_end_addr, or if w_addr == write_end_addr.
  - Otherwise w_addr increments and the FSM returns to S_READ.
- Partial trailing group (read count not a multiple of OPS): discarded; never written.
- Cycles per result = 2*OPS + 1. Total cycle_count = results × (2*OPS+1) + 1 (the acceptance cycle).
- cycle_count increments every cycle while busy, saturates at all-ones and holds in S_END.
- S_END: done=1. Stays there until start (new run) or reset.
- Address arithmetic never wraps past end addresses. An end address of 2^ADDR_W-1 terminates cleanly, with no overflow to 0.

Optional Feature:
CALC_SAT_EN
- Defined: unsigned saturating arithmetic. An add that carries clamps acc to all-ones; a subtract that borrows clamps acc to 0. ovf is still set.
- Undefined: modulo wrap as above.
- Handshake and timing are identical either way.

Test Plan:
1. Baseline run: DATA_W=32, OPS=2, add, read 0..511, write 768..1023. Lower SRAM[i]=i, upper SRAM[i]=0 -> 256 writes; mem[768+j] = {0, 4j+1}; results_written=256; cycle_count=1281; done=1; ovf=0.
2. Subtract mode: mem[0]={0,10}, mem[1]={0,3} -> write {0,7}. Swap the values to {0,3} and {0,10} -> write 0xFFFF_FFFF_FFFF_FFF9 and ovf=1. With CALC_SAT_EN -> write 0.
3. Window mismatch:
   - read 0..7, write 100..101 -> exactly 2 writes (100, 101), then S_END.
   - read 0..4, OPS=2 -> 2 writes; the partial group at address 4 is dropped.
4. Range error: read_start_addr=20, read_end_addr=10 -> S_END the cycle after start; err=1; no rd_en/wr_en ever asserted.
5. Reset mid-run: drop rst_n during S_ACC -> all outputs 0 immediately (asynchronous), no further wr_en. A subsequent start reruns case 1 correctly.
6. start pulsed while busy is ignored (results unchanged). start in S_END begins a fresh run with counters cleared.
